led_pattern_driver: RTL and testbench
=====================================

Name: led_pattern_driver

Overview:
Output stage downstream of the LED peripheral's AXI4-Lite slave register file. It consumes the software-written control, pattern, period and duty registers, and drives the physical LED pins. Supported modes are static, blink, rotate and bounce, each with a PWM brightness overlay. Configuration changes are applied glitch-free at step boundaries.

Parameters:
NUM_LEDS, 4, LED count / pattern width (2..32)
PWM_BITS, 8, PWM counter and duty width
PERIOD_W, 32, step prescaler width

Ports:
ACLK  in  1  system clock
ARESETN  in  1  reset, asynchronous, active-low
cfg_ctrl  in  32  [0] enable (live), [2:1] mode (0 static, 1 blink, 2 rotate, 3 bounce), [31:3] ignored
cfg_pattern  in  NUM_LEDS  base LED pattern
cfg_period  in  PERIOD_W  ACLK cycles per step; 0 treated as 1
cfg_duty  in  PWM_BITS  brightness; 0 = off, all-ones = fully on
cfg_update  in  1  one-cycle pulse from register block after any cfg write
leds  out  NUM_LEDS  registered LED drive
step_tick  out  1  one-cycle pulse at each step boundary
cur_pattern  out  NUM_LEDS  current working pattern (status readback)

Behaviour:
- One clock (ACLK); reset is asynchronous, active-low (ARESETN).
- Reset: leds=0, step_tick=0, cur_pattern=0, shadow mode/pattern/period/duty=0, presc=0, pwm_cnt=0, blink phase=1, dir=left, pending=0, state=IDLE.
- Shadow registers: mode, pattern, period, duty.
- FSM IDLE:
  - leds=0; presc and pwm_cnt held at 0.
  - cfg_update loads all shadows immediately and sets cur_pattern=cfg_pattern, phase=1, dir=left.
  - cfg_ctrl[0]=1 -> RUN on the next cycle.
- FSM RUN:
  - presc counts 0..max(period,1)-1. In the cycle where presc = max(period,1)-1: presc wraps to 0 and step_tick=1 on the following cycle (registered).
  - cfg_update in RUN sets pending and captures cfg values into the shadow inputs (last write wins).
  - At a boundary with pending=1:
    - load shadows; cur_pattern = new pattern; phase=1; dir=left; pending=0.
    - No mode step is applied on that boundary.
    - cfg_update coincident with the boundary cycle is applied at that same boundary.
  - At a boundary with pending=0, step per mode:
    - static: no change.
    - blink: phase toggles.
    - rotate: cur_pattern rotates left 1 (MSB wraps to bit 0).
    - bounce, dir=left: shift left. If the result has MSB set, dir flips to right.
    - bounce, dir=right: shift right. If the result has LSB set, dir flips to left.
    - bounce with a pattern already touching the edge reverses without losing bits: if MSB is set while dir=left, flip dir and shift right instead.
  - Zero pattern stays zero in all modes.
  - cfg_ctrl[0]=0 -> IDLE next cycle; leds=0 on that cycle.
  - Re-enable restarts presc at 0 and keeps cur_pattern.
- PWM:
  - pwm_cnt is a free-running PWM_BITS up-counter in RUN; it wraps.
  - pwm_on = (duty == all-ones) | (pwm_cnt < duty).
- Output: leds <= cur_pattern & {NUM_LEDS{phase & pwm_on}}, registered one cycle after the inputs it depends on.
- Async reset mid-operation: all state returns to reset values immediately; no step_tick is emitted.
- Arithmetic: presc compare uses PERIOD_W unsigned; no overflow beyond the wrap.

Test Plan:
- Reset/idle: hold ARESETN low 200ns, then release with enable=0 -> leds=0, step_tick never pulses, cur_pattern=0.
- Static full: pattern=4'b0101, duty=8'hFF, mode=0, update then enable -> leds=4'b0101 continuously from the 2nd cycle in RUN.
- Rotate: pattern=4'b0001, period=4, duty=FF, mode=2 -> step_tick every 4 cycles; leds 0001->0010->0100->1000->0001.
- Bounce plus period 0: pattern=0001, period=0, mode=3 -> step_tick every cycle; cur_pattern 0001,0010,0100,1000,0100,0010,0001,0010.
- PWM/blink: mode=1, duty=64, period=512 -> per 256 cycles, leds=pattern exactly 64 cycles during phase=1; leds=0 for the entire phase=0 step.
- Deferred update and reset mid-run: in rotate with period=8, pulse cfg_update (pattern=1100) at presc=3 -> cur_pattern unchanged until the boundary, then 1100 with no rotation on that boundary. Then assert ARESETN low mid-step -> leds=0 asynchronously.

Source files
------------

// File: rtl/led_pattern_if.sv
// Configuration and status bundle between the LED register block and the pin driver.
interface led_pattern_if #(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PERIOD_W = 32
);
    logic [31:0]         cfg_ctrl;
    logic [NUM_LEDS-1:0] cfg_pattern;
    logic [PERIOD_W-1:0] cfg_period;
    logic [PWM_BITS-1:0] cfg_duty;
    logic                cfg_update;
    logic [NUM_LEDS-1:0] leds;
    logic                step_tick;
    logic [NUM_LEDS-1:0] cur_pattern;

    modport master (
        output cfg_ctrl, cfg_pattern, cfg_period, cfg_duty, cfg_update,
        input  leds, step_tick, cur_pattern
    );

    modport slave (
        input  cfg_ctrl, cfg_pattern, cfg_period, cfg_duty, cfg_update,
        output leds, step_tick, cur_pattern
    );
endinterface

// File: rtl/led_pattern_driver.sv
// LED output stage: static/blink/rotate/bounce stepping with a PWM brightness overlay,
// configuration changes taking effect only at step boundaries while running.
module led_pattern_driver #(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PERIOD_W = 32
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    led_pattern_if.slave  bus
);
    localparam int unsigned MODE_W = 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [MODE_W-1:0]   mode_q, mode_d, stg_mode_q, stg_mode_d;
    logic [NUM_LEDS-1:0] pat_q, pat_d, stg_pat_q, stg_pat_d;
    logic [PERIOD_W-1:0] period_q, period_d, stg_period_q, stg_period_d;
    logic [PWM_BITS-1:0] duty_q, duty_d, stg_duty_q, stg_duty_d;
    logic [NUM_LEDS-1:0] cur_q, cur_d;
    logic                phase_q, phase_d;
    logic                dir_q, dir_d;       // 0 = left, 1 = right
    logic                pend_q, pend_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                tick_q, tick_d;

    logic                enable_c;
    logic [MODE_W-1:0]   cfg_mode_c;
    logic [PERIOD_W-1:0] last_c;
    logic                boundary_c;
    logic                pwm_on_c;
    logic                unused_ctrl_c;

    assign enable_c      = bus.cfg_ctrl[0];
    assign cfg_mode_c    = bus.cfg_ctrl[2:1];
    assign unused_ctrl_c = ^bus.cfg_ctrl[31:3];
    // A zero period behaves as one cycle per step.
    assign last_c        = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
    assign boundary_c    = (presc_q == last_c);
    assign pwm_on_c      = (duty_q == '1) || (pwm_q < duty_q);

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        pwm_d        = pwm_q;
        mode_d       = mode_q;
        pat_d        = pat_q;
        period_d     = period_q;
        duty_d       = duty_q;
        stg_mode_d   = stg_mode_q;
        stg_pat_d    = stg_pat_q;
        stg_period_d = stg_period_q;
        stg_duty_d   = stg_duty_q;
        cur_d        = cur_q;
        phase_d      = phase_q;
        dir_d        = dir_q;
        pend_d       = pend_q;
        leds_d       = '0;
        tick_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                presc_d = '0;
                pwm_d   = '0;
                if (bus.cfg_update) begin
                    mode_d   = cfg_mode_c;
                    pat_d    = bus.cfg_pattern;
                    period_d = bus.cfg_period;
                    duty_d   = bus.cfg_duty;
                    cur_d    = bus.cfg_pattern;
                    phase_d  = 1'b1;
                    dir_d    = 1'b0;
                    pend_d   = 1'b0;
                end
                if (enable_c) state_d = RUN;
            end
            RUN: begin
                if (bus.cfg_update) begin
                    stg_mode_d   = cfg_mode_c;
                    stg_pat_d    = bus.cfg_pattern;
                    stg_period_d = bus.cfg_period;
                    stg_duty_d   = bus.cfg_duty;
                    pend_d       = 1'b1;
                end
                if (!enable_c) begin
                    state_d = IDLE;
                    presc_d = '0;
                    pwm_d   = '0;
                end else begin
                    leds_d = cur_q & {NUM_LEDS{phase_q & pwm_on_c}};
                    pwm_d  = pwm_q + PWM_BITS'(1);
                    if (!boundary_c) begin
                        presc_d = presc_q + PERIOD_W'(1);
                    end else begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (bus.cfg_update || pend_q) begin
                            // A same-cycle write supersedes the staged one.
                            mode_d   = bus.cfg_update ? cfg_mode_c      : stg_mode_q;
                            pat_d    = bus.cfg_update ? bus.cfg_pattern : stg_pat_q;
                            period_d = bus.cfg_update ? bus.cfg_period  : stg_period_q;
                            duty_d   = bus.cfg_update ? bus.cfg_duty    : stg_duty_q;
                            cur_d    = bus.cfg_update ? bus.cfg_pattern : stg_pat_q;
                            phase_d  = 1'b1;
                            dir_d    = 1'b0;
                            pend_d   = 1'b0;
                        end else begin
                            unique case (mode_q)
                                2'd0: cur_d = cur_q;
                                2'd1: phase_d = ~phase_q;
                                2'd2: cur_d = {cur_q[NUM_LEDS-2:0], cur_q[NUM_LEDS-1]};
                                2'd3: begin
                                    // Bounce reverses at an edge instead of dropping bits.
                                    if (!dir_q) begin
                                        if (cur_q[NUM_LEDS-1]) begin
                                            cur_d = cur_q >> 1;
                                            dir_d = 1'b1;
                                        end else begin
                                            cur_d = cur_q << 1;
                                            if (cur_q[NUM_LEDS-2]) dir_d = 1'b1;
                                        end
                                    end else begin
                                        if (cur_q[0]) begin
                                            cur_d = cur_q << 1;
                                            dir_d = 1'b0;
                                        end else begin
                                            cur_d = cur_q >> 1;
                                            if (cur_q[1]) dir_d = 1'b0;
                                        end
                                    end
                                end
                                default: cur_d = cur_q;
                            endcase
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            pwm_q        <= '0;
            mode_q       <= '0;
            pat_q        <= '0;
            period_q     <= '0;
            duty_q       <= '0;
            stg_mode_q   <= '0;
            stg_pat_q    <= '0;
            stg_period_q <= '0;
            stg_duty_q   <= '0;
            cur_q        <= '0;
            phase_q      <= 1'b1;
            dir_q        <= 1'b0;
            pend_q       <= 1'b0;
            leds_q       <= '0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            pwm_q        <= pwm_d;
            mode_q       <= mode_d;
            pat_q        <= pat_d;
            period_q     <= period_d;
            duty_q       <= duty_d;
            stg_mode_q   <= stg_mode_d;
            stg_pat_q    <= stg_pat_d;
            stg_period_q <= stg_period_d;
            stg_duty_q   <= stg_duty_d;
            cur_q        <= cur_d;
            phase_q      <= phase_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            leds_q       <= leds_d;
            tick_q       <= tick_d;
        end
    end

    assign bus.leds        = leds_q;
    assign bus.step_tick   = tick_q;
    assign bus.cur_pattern = cur_q;
endmodule

// File: tb/tb_led_pattern_driver.sv
// Randomized and directed bench for led_pattern_driver against a cycle-level behavioural model.
module tb_led_pattern_driver;
    logic ACLK;
    logic ARESETN;

    led_pattern_if #(.NUM_LEDS(4), .PWM_BITS(8), .PERIOD_W(32)) bus ();

    led_pattern_driver #(.NUM_LEDS(4), .PWM_BITS(8), .PERIOD_W(32)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: values the DUT registers hold during the current cycle.
    bit          m_run;
    int unsigned m_presc, m_pwm, m_mode, m_pat, m_per, m_duty, m_cur;
    bit          m_phase, m_dir, m_pend;
    int unsigned s_mode, s_pat, s_per, s_duty;
    int unsigned m_leds;
    bit          m_tick;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic void model_reset();
        m_run = 0; m_presc = 0; m_pwm = 0; m_mode = 0; m_pat = 0; m_per = 0; m_duty = 0;
        m_cur = 0; m_phase = 1; m_dir = 0; m_pend = 0; m_leds = 0; m_tick = 0;
        s_mode = 0; s_pat = 0; s_per = 0; s_duty = 0;
    endfunction

    function automatic void load_cfg(input int unsigned mo, input int unsigned pa,
                                     input int unsigned pe, input int unsigned du);
        m_mode = mo; m_pat = pa; m_per = pe; m_duty = du;
        m_cur = pa; m_phase = 1; m_dir = 0; m_pend = 0;
    endfunction

    // One step of the chosen animation on a 4-bit pattern, using plain arithmetic.
    function automatic void advance();
        case (m_mode)
            1: m_phase = !m_phase;
            2: m_cur = (m_cur * 2) % 16 + m_cur / 8;
            3: begin
                if (!m_dir) begin
                    if (m_cur >= 8) begin m_cur = m_cur / 2; m_dir = 1; end
                    else begin m_cur = (m_cur * 2) % 16; if (m_cur >= 8) m_dir = 1; end
                end else begin
                    if (m_cur % 2 == 1) begin m_cur = (m_cur * 2) % 16; m_dir = 0; end
                    else begin m_cur = m_cur / 2; if (m_cur % 2 == 1) m_dir = 0; end
                end
            end
            default: ;
        endcase
    endfunction

    // Advance the model across one rising edge with the inputs currently on the bus.
    function automatic void model_step();
        bit          en   = bus.cfg_ctrl[0];
        bit          upd  = bus.cfg_update;
        int unsigned mo   = int'(bus.cfg_ctrl[2:1]);
        int unsigned pa   = int'(bus.cfg_pattern);
        int unsigned pe   = bus.cfg_period;
        int unsigned du   = int'(bus.cfg_duty);
        int unsigned len  = (m_per == 0) ? 1 : m_per;
        bit          on;
        m_tick = 0;
        if (!m_run) begin
            m_leds = 0; m_presc = 0; m_pwm = 0;
            if (upd) load_cfg(mo, pa, pe, du);
            m_run = en;
        end else if (!en) begin
            m_leds = 0; m_presc = 0; m_pwm = 0; m_run = 0;
            if (upd) begin s_mode = mo; s_pat = pa; s_per = pe; s_duty = du; m_pend = 1; end
        end else begin
            on     = m_phase && (m_duty == 255 || m_pwm < m_duty);
            m_leds = on ? m_cur : 0;
            m_pwm  = (m_pwm + 1) % 256;
            if (m_presc + 1 == len) begin
                m_presc = 0; m_tick = 1;
                if (upd)         load_cfg(mo, pa, pe, du);
                else if (m_pend) load_cfg(s_mode, s_pat, s_per, s_duty);
                else             advance();
            end else begin
                m_presc++;
                if (upd) begin s_mode = mo; s_pat = pa; s_per = pe; s_duty = du; m_pend = 1; end
            end
        end
    endfunction

    // Check the current cycle, then drive the next cycle's inputs.
    task automatic cyc(input logic [31:0] ctrl, input logic [3:0] pat, input logic [31:0] per,
                       input logic [7:0] duty, input logic upd);
        @(negedge ACLK);
        check("leds", 32'(bus.leds), m_leds);
        check("step_tick", 32'(bus.step_tick), 32'(m_tick));
        check("cur_pattern", 32'(bus.cur_pattern), m_cur);
        bus.cfg_ctrl    = ctrl;
        bus.cfg_pattern = pat;
        bus.cfg_period  = per;
        bus.cfg_duty    = duty;
        bus.cfg_update  = upd;
        model_step();
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++)
            cyc(bus.cfg_ctrl, bus.cfg_pattern, bus.cfg_period, bus.cfg_duty, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge ACLK);
        #2 ARESETN = 1'b0;
        #1;
        check("rst_leds", 32'(bus.leds), 32'h0);
        check("rst_tick", 32'(bus.step_tick), 32'h0);
        check("rst_cur", 32'(bus.cur_pattern), 32'h0);
        model_reset();
        @(negedge ACLK);
        check("rst_hold_tick", 32'(bus.step_tick), 32'h0);
        ARESETN = 1'b1;
        bus.cfg_update = 1'b0;
        model_step();
    endtask

    logic [3:0] bounce_tbl [8];
    logic [3:0] rp;
    logic [7:0] rd;

    initial begin
        ARESETN = 1'b0;
        bus.cfg_ctrl = '0; bus.cfg_pattern = '0; bus.cfg_period = '0;
        bus.cfg_duty = '0; bus.cfg_update = 1'b0;
        model_reset();
        repeat (20) @(negedge ACLK);
        ARESETN = 1'b1;
        model_step();
        hold(20);

        // Static, full brightness.
        cyc(32'h0, 4'b0101, 32'd3, 8'hFF, 1'b1);
        cyc(32'h1, 4'b0101, 32'd3, 8'hFF, 1'b0);
        hold(20);
        cyc(32'h0, 4'b0101, 32'd3, 8'hFF, 1'b0);
        hold(3);

        // Rotate, period 4.
        cyc(32'h4, 4'b0001, 32'd4, 8'hFF, 1'b1);
        cyc(32'h5, 4'b0001, 32'd4, 8'hFF, 1'b0);
        hold(24);
        cyc(32'h4, 4'b0001, 32'd4, 8'hFF, 1'b0);
        hold(2);

        // Bounce with period 0: one step per cycle.
        bounce_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        cyc(32'h6, 4'b0001, 32'd0, 8'hFF, 1'b1);
        cyc(32'h7, 4'b0001, 32'd0, 8'hFF, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(32'h7, 4'b0001, 32'd0, 8'hFF, 1'b0);
            check("bounce_seq", 32'(bus.cur_pattern), 32'(bounce_tbl[i]));
        end
        cyc(32'h6, 4'b0001, 32'd0, 8'hFF, 1'b0);
        hold(2);

        // Blink with PWM duty 64, period 512.
        cyc(32'h2, 4'b1011, 32'd512, 8'd64, 1'b1);
        cyc(32'h3, 4'b1011, 32'd512, 8'd64, 1'b0);
        hold(1100);
        cyc(32'h2, 4'b1011, 32'd512, 8'd64, 1'b0);
        hold(2);

        // Rotate period 8 with a deferred update mid-step, then reset mid-step.
        cyc(32'h4, 4'b0011, 32'd8, 8'hFF, 1'b1);
        cyc(32'h5, 4'b0011, 32'd8, 8'hFF, 1'b0);
        hold(11);
        cyc(32'h5, 4'b1100, 32'd8, 8'hFF, 1'b1);
        hold(20);
        async_reset();
        hold(10);

        // Randomized configuration traffic.
        for (int i = 0; i < 2500; i++) begin
            rp = 4'($urandom);
            case ($urandom_range(0, 3))
                0: rd = 8'hFF;
                1: rd = 8'h00;
                default: rd = 8'($urandom);
            endcase
            cyc({29'($urandom), 2'($urandom), 1'($urandom_range(0, 30) != 0)},
                rp, 32'($urandom_range(0, 6)), rd, 1'($urandom_range(0, 11) == 0));
            if ($urandom_range(0, 499) == 0) async_reset();
        end
        hold(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
